// File: rtl/seg7_scan_driver_pkg.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver_pkg
//
// Shared definitions for the multiplexed 7-segment display driver.
//
// Segment bit order used everywhere in this block:
//   seg[6] = a, seg[5] = b, seg[4] = c, seg[3] = d,
//   seg[2] = e, seg[1] = f, seg[0] = g
// A '1' in a pattern means the segment is lit (before any output polarity
// inversion applied at the pins).
// ----------------------------------------------------------------------------
package seg7_scan_driver_pkg;

    typedef logic [6:0] seg_t;

    // Bit positions of the individual segments inside seg_t.
    localparam int SEG_BIT_A = 6;
    localparam int SEG_BIT_B = 5;
    localparam int SEG_BIT_C = 4;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 2;
    localparam int SEG_BIT_F = 1;
    localparam int SEG_BIT_G = 0;

    // Digit patterns, {a,b,c,d,e,f,g}.
    localparam seg_t SEG_0    = 7'b1111110;
    localparam seg_t SEG_1    = 7'b0110000;
    localparam seg_t SEG_2    = 7'b1101101;
    localparam seg_t SEG_3    = 7'b1111001;
    localparam seg_t SEG_4    = 7'b0110011;
    localparam seg_t SEG_5    = 7'b1011011;
    localparam seg_t SEG_6    = 7'b1011111;
    localparam seg_t SEG_7    = 7'b1110000;
    localparam seg_t SEG_8    = 7'b1111111;
    localparam seg_t SEG_9    = 7'b1111011;
    // Non-decimal codes 10..15 are shown as a single middle bar.
    localparam seg_t SEG_DASH = 7'b0000001;
    localparam seg_t SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// ----------------------------------------------------------------------------
// bcd_to_seg7
//
// Purely combinational 4-bit BCD to 7-segment decoder. Codes 0..9 give the
// standard digit shapes; codes 10..15 give a dash.
//
// Ports:
//   bcd  in   4  BCD digit code
//   seg  out  7  lit segments, {a,b,c,d,e,f,g}, active-high
// ----------------------------------------------------------------------------
module bcd_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed N-digit 7-segment display driver. A packed BCD word is
// accepted over a valid/ready handshake into a pending buffer and copied to
// the display buffer only when the scan wraps back to digit 0, so a frame is
// never drawn from two different words. One digit is enabled at a time for
// REFRESH_DIV clock cycles. Optional leading-zero blanking and an output
// polarity switch for common-anode boards are provided.
//
// Parameters:
//   NUM_DIGITS   number of digits scanned (1..8)
//   REFRESH_DIV  clock cycles each digit stays enabled (>= 2)
//   ACTIVE_LOW   1 inverts seg, dp and an at the output registers
//
// Ports:
//   clk          in   1             system clock
//   rst          in   1             synchronous, active-high reset
//   load_valid   in   1             new display word offered
//   load_ready   out  1             pending buffer empty, word can be taken
//   bcd_in       in   4*NUM_DIGITS  packed BCD, digit 0 (LSD) in [3:0]
//   dp_in        in   NUM_DIGITS    decimal point per digit
//   blank_lz_en  in   1             leading-zero blanking enable (live)
//   seg          out  7             {a,b,c,d,e,f,g} of active digit, registered
//   dp           out  1             decimal point of active digit, registered
//   an           out  NUM_DIGITS    one-hot digit enable, registered
//   frame_done   out  1             one-cycle pulse on the wrap to digit 0
// ----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz_en,
    output seg_t                    seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // XOR masks that turn an active-high value into the pin level.
    localparam seg_t                  SEG_POL = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};

    logic [PRE_W-1:0]            prescaler;
    logic [IDX_W-1:0]            idx;
    logic [NUM_DIGITS-1:0][3:0]  disp_bcd;
    logic [NUM_DIGITS-1:0]       disp_dp;
    logic [NUM_DIGITS-1:0][3:0]  pend_bcd;
    logic [NUM_DIGITS-1:0]       pend_dp;
    logic                        pending_full;

    logic                        tick;
    logic                        frame_wrap;
    logic                        load_fire;

    logic [3:0]                  cur_bcd;
    seg_t                        cur_pattern;
    logic                        zero_run;
    logic [NUM_DIGITS-1:0]       lz_mask;
    logic                        cur_blank;
    seg_t                        seg_next;
    logic [NUM_DIGITS-1:0]       an_next;

    // ------------------------------------------------------------------------
    // Scan timing and handshake
    // ------------------------------------------------------------------------
    assign tick       = (prescaler == PRE_LAST);
    assign frame_wrap = tick && (idx == IDX_LAST);
    assign frame_done = frame_wrap && !rst;

    assign load_ready = !pending_full && !rst;
    assign load_fire  = load_valid && load_ready;

    // ------------------------------------------------------------------------
    // Current digit decode
    // ------------------------------------------------------------------------
    assign cur_bcd = disp_bcd[idx];

    bcd_to_seg7 u_decode (
        .bcd (cur_bcd),
        .seg (cur_pattern)
    );

    // lz_mask[i] is set when display digits i..NUM_DIGITS-1 are all zero,
    // built by walking down from the most significant digit.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch or
        // loop can skip it, so no latch is inferred.
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (disp_bcd[i] == 4'd0);
            lz_mask[i] = zero_run;
        end
    end

    // Digit 0 always shows, so a zero value still displays as "0".
    assign cur_blank = blank_lz_en && (idx != '0) && lz_mask[idx];

    always_comb begin
        seg_next     = cur_blank ? SEG_OFF : cur_pattern;
        an_next      = '0;
        an_next[idx] = 1'b1;
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            prescaler    <= '0;
            idx          <= '0;
            disp_bcd     <= '0;
            disp_dp      <= '0;
            pend_bcd     <= '0;
            pend_dp      <= '0;
            pending_full <= 1'b0;
            seg          <= SEG_POL;
            dp           <= ACTIVE_LOW;
            an           <= AN_POL;
        end else begin
            seg <= seg_next ^ SEG_POL;
            dp  <= disp_dp[idx] ^ ACTIVE_LOW;
            an  <= an_next ^ AN_POL;

            if (tick) begin
                prescaler <= '0;
                idx       <= frame_wrap ? '0 : idx + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            // Display only changes on a frame boundary, and only if a word is
            // waiting.
            if (frame_wrap && pending_full) begin
                disp_bcd     <= pend_bcd;
                disp_dp      <= pend_dp;
                pending_full <= 1'b0;
            end

            // A capture requires an empty pending buffer, so it never collides
            // with the transfer above; a word captured on a boundary is shown
            // from the following frame.
            if (load_fire) begin
                pend_bcd     <= bcd_in;
                pend_dp      <= dp_in;
                pending_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Two instances share all inputs: one with active-high pins, one with
// ACTIVE_LOW=1. A frame-position model pushes the expected post-edge outputs
// into a queue before each clock edge; the test tasks pop and compare them on
// the following falling edge, and add direct checks of the display patterns.
// ----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int D     = 4;
    localparam int FRAME = N * D;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fd;
        logic       rdy;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz_en = 1'b0;

    logic        load_ready, load_ready_al;
    logic [6:0]  seg, seg_al;
    logic        dp, dp_al;
    logic [3:0]  an, an_al;
    logic        frame_done, frame_done_al;

    obs_t obs, obs_al;
    assign obs    = {seg, dp, an, frame_done, load_ready};
    assign obs_al = {seg_al, dp_al, an_al, frame_done_al, load_ready_al};

    int checks   = 0;
    int failures = 0;

    // Model state: position within the frame plus the two word buffers.
    int          m_phase = 0;
    logic [15:0] m_disp = '0, m_pend = '0;
    logic [3:0]  m_dp = '0, m_pend_dp = '0;
    logic        m_full = 1'b0;
    logic [6:0]  seg_tab [16];
    obs_t        exp_q [$];

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(D), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .bcd_in(bcd_in), .dp_in(dp_in), .blank_lz_en(blank_lz_en),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(D), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready_al),
        .bcd_in(bcd_in), .dp_in(dp_in), .blank_lz_en(blank_lz_en),
        .seg(seg_al), .dp(dp_al), .an(an_al), .frame_done(frame_done_al)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic obs_t invert(input obs_t e);
        obs_t r = e;
        r.seg = ~e.seg;
        r.dp  = ~e.dp;
        r.an  = ~e.an;
        return r;
    endfunction

    // Predict the outputs seen after the next rising edge, given the inputs
    // currently driven, and push them to the scoreboard.
    task automatic model_step();
        obs_t       e;
        int         d;
        logic [3:0] digit;
        logic       fire;
        e = '0;
        if (rst) begin
            m_phase = 0; m_disp = '0; m_dp = '0;
            m_pend = '0; m_pend_dp = '0; m_full = 1'b0;
        end else begin
            d     = m_phase / D;
            digit = m_disp[4*d +: 4];
            e.an  = 4'(1 << d);
            e.dp  = m_dp[d];
            if (blank_lz_en && d > 0 && (m_disp >> (4*d)) == 16'h0) e.seg = 7'b0;
            else e.seg = seg_tab[digit];
            fire = load_valid && !m_full;
            if (m_phase == FRAME - 1 && m_full) begin
                m_disp = m_pend; m_dp = m_pend_dp; m_full = 1'b0;
            end
            if (fire) begin
                m_pend = bcd_in; m_pend_dp = dp_in; m_full = 1'b1;
            end
            m_phase = (m_phase + 1) % FRAME;
        end
        e.fd  = !rst && (m_phase == FRAME - 1);
        e.rdy = !rst && !m_full;
        exp_q.push_back(e);
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t e;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance(); e = exp_q.pop_front(); checks++;
            if ({obs, obs_al} !== {e, invert(e)}) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%h/%h want=%h/%h", i, obs, obs_al, e, invert(e));
            end
        end
        checks++;
        if (seg !== 7'h00 || an !== 4'h0 || seg_al !== 7'h7f || an_al !== 4'hf || dp_al !== 1'b1) begin
            failures++;
            $display("FAIL reset_levels got seg=%b an=%b seg_al=%b an_al=%b dp_al=%b want 0000000 0000 1111111 1111 1",
                     seg, an, seg_al, an_al, dp_al);
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        obs_t       e;
        logic [3:0] want_an;
        int         fd_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            advance(); e = exp_q.pop_front(); checks++;
            if ({obs, obs_al} !== {e, invert(e)}) begin
                failures++;
                $display("FAIL scan cyc=%0d got=%h/%h want=%h/%h", i, obs, obs_al, e, invert(e));
            end
            want_an = 4'b0001 << (i / D);
            checks++;
            if (seg !== 7'b1111110 || an !== want_an) begin
                failures++;
                $display("FAIL scan_pattern cyc=%0d got seg=%b an=%b want seg=1111110 an=%b", i, seg, an, want_an);
            end
            if (frame_done === 1'b1) fd_cnt++;
        end
        checks++;
        if (fd_cnt !== 1) begin
            failures++;
            $display("FAIL scan_frame_done got %0d pulses want 1", fd_cnt);
        end
    endtask

    task automatic test_load();
        obs_t e;
        for (int i = 0; i < 5; i++) begin
            advance(); e = exp_q.pop_front(); checks++;
            if ({obs, obs_al} !== {e, invert(e)}) begin
                failures++;
                $display("FAIL load_pre cyc=%0d got=%h/%h want=%h/%h", i, obs, obs_al, e, invert(e));
            end
        end
        bcd_in = 16'h1234; dp_in = 4'b0000; load_valid = 1'b1;
        advance(); e = exp_q.pop_front(); load_valid = 1'b0; checks++;
        if ({obs, obs_al} !== {e, invert(e)}) begin
            failures++;
            $display("FAIL load_capture got=%h/%h want=%h/%h", obs, obs_al, e, invert(e));
        end
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL load_ready_drop got=%b want=0", load_ready);
        end
        while (m_phase != 0) begin
            advance(); e = exp_q.pop_front(); checks++;
            if ({obs, obs_al} !== {e, invert(e)} || seg !== 7'b1111110) begin
                failures++;
                $display("FAIL load_old_frame got=%h/%h want=%h/%h", obs, obs_al, e, invert(e));
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            advance(); e = exp_q.pop_front(); checks++;
            if ({obs, obs_al} !== {e, invert(e)}) begin
                failures++;
                $display("FAIL load_frame cyc=%0d got=%h/%h want=%h/%h", i, obs, obs_al, e, invert(e));
            end
            if (i < D || i >= FRAME - D) begin
                checks++;
                if (seg !== ((i < D) ? 7'b0110011 : 7'b0110000)) begin
                    failures++;
                    $display("FAIL load_digits cyc=%0d got seg=%b want %b", i, seg,
                             (i < D) ? 7'b0110011 : 7'b0110000);
                end
            end
        end
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_ready_return got=%b want=1", load_ready);
        end
    endtask

    task automatic test_blank();
        obs_t       e;
        logic [6:0] want;
        blank_lz_en = 1'b1;
        bcd_in = 16'h0007; dp_in = 4'b0000; load_valid = 1'b1;
        advance(); e = exp_q.pop_front(); load_valid = 1'b0; checks++;
        if ({obs, obs_al} !== {e, invert(e)}) begin
            failures++;
            $display("FAIL blank_capture got=%h/%h want=%h/%h", obs, obs_al, e, invert(e));
        end
        while (m_phase != 0) begin
            advance(); e = exp_q.pop_front(); checks++;
            if ({obs, obs_al} !== {e, invert(e)}) begin
                failures++;
                $display("FAIL blank_wait got=%h/%h want=%h/%h", obs, obs_al, e, invert(e));
            end
        end
        for (int pass = 0; pass < 2; pass++) begin
            blank_lz_en = (pass == 0);
            for (int i = 0; i < FRAME; i++) begin
                advance(); e = exp_q.pop_front(); checks++;
                if ({obs, obs_al} !== {e, invert(e)}) begin
                    failures++;
                    $display("FAIL blank_frame pass=%0d cyc=%0d got=%h/%h want=%h/%h", pass, i, obs, obs_al, e, invert(e));
                end
                want = (i < D) ? 7'b1110000 : ((pass == 0) ? 7'b0000000 : 7'b1111110);
                checks++;
                if (seg !== want) begin
                    failures++;
                    $display("FAIL blank_digits pass=%0d cyc=%0d got seg=%b want %b", pass, i, seg, want);
                end
            end
        end
    endtask

    task automatic test_dash_dp();
        obs_t       e;
        logic [7:0] want;
        blank_lz_en = 1'b1;
        bcd_in = 16'h00A0; dp_in = 4'b0010; load_valid = 1'b1;
        advance(); e = exp_q.pop_front(); load_valid = 1'b0; checks++;
        if ({obs, obs_al} !== {e, invert(e)}) begin
            failures++;
            $display("FAIL dash_capture got=%h/%h want=%h/%h", obs, obs_al, e, invert(e));
        end
        while (m_phase != 0) begin
            advance(); e = exp_q.pop_front(); checks++;
            if ({obs, obs_al} !== {e, invert(e)}) begin
                failures++;
                $display("FAIL dash_wait got=%h/%h want=%h/%h", obs, obs_al, e, invert(e));
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            advance(); e = exp_q.pop_front(); checks++;
            if ({obs, obs_al} !== {e, invert(e)}) begin
                failures++;
                $display("FAIL dash_frame cyc=%0d got=%h/%h want=%h/%h", i, obs, obs_al, e, invert(e));
            end
            case (i / D)
                0:       want = {7'b1111110, 1'b0};
                1:       want = {7'b0000001, 1'b1};
                default: want = {7'b0000000, 1'b0};
            endcase
            checks++;
            if ({seg, dp} !== want) begin
                failures++;
                $display("FAIL dash_digits cyc=%0d got seg/dp=%b want %b", i, {seg, dp}, want);
            end
        end
        blank_lz_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        obs_t e;
        bcd_in = 16'h5678; dp_in = 4'b0000; load_valid = 1'b1;
        advance(); e = exp_q.pop_front(); checks++;
        if ({obs, obs_al} !== {e, invert(e)}) begin
            failures++;
            $display("FAIL b2b_capture got=%h/%h want=%h/%h", obs, obs_al, e, invert(e));
        end
        // Keep offering a second word while the first is still pending.
        bcd_in = 16'h9999; dp_in = 4'b1111;
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_full got=%b want=0", load_ready);
        end
        while (m_phase != 0) begin
            advance(); e = exp_q.pop_front(); checks++;
            if ({obs, obs_al} !== {e, invert(e)}) begin
                failures++;
                $display("FAIL b2b_offer got=%h/%h want=%h/%h", obs, obs_al, e, invert(e));
            end
        end
        load_valid = 1'b0;
        // First word on screen; at the last cycle of the frame offer a word that
        // is captured on the boundary itself.
        for (int i = 0; i < FRAME; i++) begin
            if (i == FRAME - 1) begin
                bcd_in = 16'h4321; dp_in = 4'b0000; load_valid = 1'b1;
            end
            advance(); e = exp_q.pop_front(); load_valid = 1'b0; checks++;
            if ({obs, obs_al} !== {e, invert(e)}) begin
                failures++;
                $display("FAIL b2b_frame1 cyc=%0d got=%h/%h want=%h/%h", i, obs, obs_al, e, invert(e));
            end
            if (i < D || (i >= FRAME - D && i < FRAME - 1)) begin
                checks++;
                if (seg !== ((i < D) ? 7'b1111111 : 7'b1011011)) begin
                    failures++;
                    $display("FAIL b2b_first_word cyc=%0d got seg=%b", i, seg);
                end
            end
        end
        checks++;
        if (load_ready !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_boundary_capture got ready=%b fd=%b want 0 0", load_ready, frame_done);
        end
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < FRAME; i++) begin
                advance(); e = exp_q.pop_front(); checks++;
                if ({obs, obs_al} !== {e, invert(e)}) begin
                    failures++;
                    $display("FAIL b2b_frame%0d cyc=%0d got=%h/%h want=%h/%h", f + 2, i, obs, obs_al, e, invert(e));
                end
                if (i < D) begin
                    checks++;
                    if (seg !== ((f == 0) ? 7'b1111111 : 7'b0110000)) begin
                        failures++;
                        $display("FAIL b2b_digit0 frame=%0d got seg=%b", f + 2, seg);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e;
        bcd_in = 16'h2222; dp_in = 4'b1111; load_valid = 1'b1;
        advance(); e = exp_q.pop_front(); load_valid = 1'b0; checks++;
        if ({obs, obs_al} !== {e, invert(e)}) begin
            failures++;
            $display("FAIL rmid_capture got=%h/%h want=%h/%h", obs, obs_al, e, invert(e));
        end
        for (int i = 0; i < 6; i++) begin
            rst = (i == 5);
            advance(); e = exp_q.pop_front(); checks++;
            if ({obs, obs_al} !== {e, invert(e)}) begin
                failures++;
                $display("FAIL rmid_pre cyc=%0d got=%h/%h want=%h/%h", i, obs, obs_al, e, invert(e));
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            advance(); e = exp_q.pop_front(); checks++;
            if ({obs, obs_al} !== {e, invert(e)}) begin
                failures++;
                $display("FAIL rmid_after cyc=%0d got=%h/%h want=%h/%h", i, obs, obs_al, e, invert(e));
            end
            checks++;
            if (seg_al !== 7'b0000001 || dp_al !== 1'b1 || (i < D && an_al !== 4'b1110)) begin
                failures++;
                $display("FAIL rmid_display cyc=%0d got seg_al=%b dp_al=%b an_al=%b", i, seg_al, dp_al, an_al);
            end
        end
    endtask

    initial begin
        seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                    7'b1111111, 7'b1111011, 7'b0000001, 7'b0000001,
                    7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};
        @(negedge clk);
        test_reset();
        test_scan();
        test_load();
        test_blank();
        test_dash_dp();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
